fetch_queue: RTL

//  Parametrised instruction buffer between the fetch stage and the decode pipeline register.
//  - Decouples fetch from decode: fetch keeps running while decode stalls (load-use, multi-cycle EX).
//  - Flushes in one cycle on a taken branch.
//  - Presents a canonical NOP to decode when empty, so downstream stages see a bubble, never stale data.
//  - Replaces direct fetch->pipeline_fetch coupling; generalises it in depth, width and bypass mode.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and the decode pipeline register.
// Presents a NOP bubble when empty, flushes in one cycle, optional zero-latency bypass when empty.
module fetch_queue #(
    parameter int unsigned          XLEN   = 32,
    parameter int unsigned          DEPTH  = 4,
    parameter bit                   BYPASS = 1'b0,
    parameter logic [XLEN-1:0]      NOP    = XLEN'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [XLEN-1:0]              enq_instr,
    input  logic [XLEN-1:0]              enq_pc,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [XLEN-1:0]              deq_instr,
    output logic [XLEN-1:0]              deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic empty;
    logic bypass_path;
    logic enq_fire;
    logic deq_fire;
    logic store;
    logic pop;

    // Handshake, output mux and next-state pointer/count arithmetic
    always_comb begin
        empty       = (count_q == '0);
        bypass_path = BYPASS && empty && enq_valid;
        enq_ready   = (count_q < CW'(DEPTH)) && !flush;
        deq_valid   = (!empty || bypass_path) && !flush;
        enq_fire    = enq_valid && enq_ready;
        deq_fire    = deq_valid && deq_ready;
        // A bypassed word consumed in the same cycle never touches storage.
        store       = enq_fire && !(bypass_path && deq_fire);
        pop         = deq_fire && !empty;

        deq_instr = NOP;
        deq_pc    = '0;
        if (deq_valid) begin
            if (empty) begin
                deq_instr = enq_instr;
                deq_pc    = enq_pc;
            end else begin
                deq_instr = instr_mem_q[rd_ptr_q];
                deq_pc    = pc_mem_q[rd_ptr_q];
            end
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            if (store && !pop)      count_d = count_q + CW'(1);
            else if (!store && pop) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers; reset overrides flush and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (!rst && store) begin
            instr_mem_q[wr_ptr_q] <= enq_instr;
            pc_mem_q[wr_ptr_q]    <= enq_pc;
        end
    end

    assign count = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule
